// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux block (packet locking: STREAM_MUX_LOCK_EN).
package stream_mux_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Channel-index width for n channels; never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N-1.
// Used by stream_mux in every build (with or without STREAM_MUX_LOCK_EN).
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int unsigned N     = 8,
   localparam int unsigned SEL_W = sel_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] gnt_idx
);

   logic                    found;
   logic [SEL_W-1:0]        idx;
   int unsigned             j;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      j       = 0;
      for (int unsigned i = 0; i < N; i++) begin
         j = 32'(ptr) + i;
         if (j >= N) j = j - N;
         idx = SEL_W'(j);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/stream_mux.sv
// Registered N-to-1 valid/ready stream mux with round-robin or fixed select.
// Define STREAM_MUX_LOCK_EN to hold a grant for a whole packet (adds in_last/out_last).
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter  int unsigned N     = 8,
   parameter  int unsigned W     = 8,
   localparam int unsigned SEL_W = sel_width(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   input  logic [N*W-1:0]   in_data,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEL_W-1:0] out_sel
`ifdef STREAM_MUX_LOCK_EN
   ,
   input  logic [N-1:0]     in_last,
   output logic             out_last
`endif
);

   logic             ld_c;
   logic             xfer_c;
   logic [N-1:0]     g;
   logic [N-1:0]     rr_gnt;
   logic [SEL_W-1:0] rr_idx;
   logic [SEL_W-1:0] k;
   logic [SEL_W-1:0] p;
   logic [SEL_W-1:0] p_next;
   logic [W-1:0]     ch_data [N];

`ifdef STREAM_MUX_LOCK_EN
   logic             locked;
   logic [SEL_W-1:0] lock_idx;
`endif

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*W +: W];
   end

   rr_arbiter #(.N(N)) u_arb (
      .req     (in_valid),
      .ptr     (p),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   // Grant selection: lock overrides mode; out-of-range sel grants nobody.
   always_comb begin
      g = '0;
      k = '0;
      if (mode == MODE_FIXED) begin
         k = sel;
         if (32'(sel) < N) g[sel] = in_valid[sel];
      end else begin
         g = rr_gnt;
         k = rr_idx;
      end
`ifdef STREAM_MUX_LOCK_EN
      if (locked) begin
         g           = '0;
         g[lock_idx] = in_valid[lock_idx];
         k           = lock_idx;
      end
`endif
   end

   assign ld_c     = !out_valid || out_ready;
   assign xfer_c   = ld_c && (|g);
   assign in_ready = reset ? '0 : (g & {N{ld_c}});
   assign p_next   = (k == SEL_W'(N - 1)) ? '0 : k + SEL_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         p         <= '0;
`ifdef STREAM_MUX_LOCK_EN
         out_last  <= 1'b0;
         locked    <= 1'b0;
         lock_idx  <= '0;
`endif
      end else begin
         if (ld_c) begin
            out_valid <= xfer_c;
            if (xfer_c) begin
               out_data <= ch_data[k];
               out_sel  <= k;
`ifdef STREAM_MUX_LOCK_EN
               out_last <= in_last[k];
`endif
            end
         end
`ifdef STREAM_MUX_LOCK_EN
         // Pointer moves only when a packet ends; mid-packet beats pin the grant.
         if (xfer_c) begin
            if (in_last[k]) begin
               locked <= 1'b0;
               p      <= p_next;
            end else begin
               locked   <= 1'b1;
               lock_idx <= k;
            end
         end
`else
         if (xfer_c) p <= p_next;
`endif
      end
   end

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux (N=8 main instance, N=6 instance for out-of-range sel).
// Honours STREAM_MUX_LOCK_EN when defined at compile time.
module tb_stream_mux;

   logic        clk;
   logic        reset;
   logic        mode;
   logic [2:0]  sel;
   logic [63:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_sel;
   logic [7:0]  in_last;
   logic        out_last;
   logic [5:0]  in_ready6;
   logic [7:0]  out_data6;
   logic        out_valid6;
   logic [2:0]  out_sel6;
   logic        out_last6;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int   m_p;
   bit   m_ov;
   logic [7:0] m_od;
   int   m_os;
   bit   m_ol;
   bit   m_lk;
   int   m_lki;

   stream_mux #(.N(8), .W(8)) u_dut (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sel(out_sel)
`ifdef STREAM_MUX_LOCK_EN
      , .in_last(in_last), .out_last(out_last)
`endif
   );

   stream_mux #(.N(6), .W(8)) u_dut6 (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel),
      .in_data(in_data[47:0]), .in_valid(in_valid[5:0]), .in_ready(in_ready6),
      .out_data(out_data6), .out_valid(out_valid6), .out_ready(1'b1),
      .out_sel(out_sel6)
`ifdef STREAM_MUX_LOCK_EN
      , .in_last(in_last[5:0]), .out_last(out_last6)
`endif
   );

`ifndef STREAM_MUX_LOCK_EN
   assign out_last  = 1'b0;
   assign out_last6 = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Channel the spec's rules pick this cycle, or -1.
   function automatic int pick();
      int c;
      if (m_lk) return in_valid[m_lki] ? m_lki : -1;
      if (mode) return in_valid[sel] ? int'(sel) : -1;
      for (int i = 0; i < 8; i++) begin
         c = (m_p + i) % 8;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   // One clock: check in_ready, advance model at the edge, check registered outputs.
   task automatic step();
      int   ch;
      bit   ld;
      logic [7:0] exp_rdy;
      #1;
      ld = !m_ov || out_ready;
      ch = pick();
      exp_rdy = (!reset && ld && ch >= 0) ? 8'(1 << ch) : 8'h00;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      @(posedge clk);
      if (reset) begin
         m_ov = 0; m_od = '0; m_os = 0; m_ol = 0; m_p = 0; m_lk = 0; m_lki = 0;
      end else if (ld) begin
         if (ch >= 0) begin
            m_ov = 1;
            m_od = in_data[ch*8 +: 8];
            m_os = ch;
`ifdef STREAM_MUX_LOCK_EN
            m_ol = in_last[ch];
            if (in_last[ch]) begin
               m_lk = 0;
               m_p  = (ch + 1) % 8;
            end else begin
               m_lk  = 1;
               m_lki = ch;
            end
`else
            m_p = (ch + 1) % 8;
`endif
         end else begin
            m_ov = 0;
         end
      end
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_data", 64'(out_data), 64'(m_od));
      chk("out_sel", 64'(out_sel), 64'(m_os));
`ifdef STREAM_MUX_LOCK_EN
      chk("out_last", 64'(out_last), 64'(m_ol));
`endif
      @(negedge clk);
   endtask

   task automatic rand_data();
      in_data = {$urandom, $urandom};
   endtask

   initial begin
      m_p = 0; m_ov = 0; m_od = '0; m_os = 0; m_ol = 0; m_lk = 0; m_lki = 0;
      reset = 1'b1; mode = 1'b1; sel = '0; in_data = '0; in_valid = '0;
      out_ready = 1'b1; in_last = 8'hFF;
      @(negedge clk);
      step();
      step();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_sel", 64'(out_sel), 64'(0));

      // Fixed select of channel 3
      reset = 1'b0; mode = 1'b1; sel = 3'd3; in_valid = 8'h08;
      rand_data(); in_data[31:24] = 8'hA5;
      #1 chk("fix3_rdy", 64'(in_ready), 64'h08);
      step();
      chk("fix3_valid", 64'(out_valid), 64'(1));
      chk("fix3_data", 64'(out_data), 64'hA5);
      chk("fix3_sel", 64'(out_sel), 64'd3);

      // Round-robin, every channel valid: 0..7 then wrap to 0
      reset = 1'b1; step(); reset = 1'b0;
      mode = 1'b0; in_valid = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         rand_data();
         step();
         chk("rr_wrap_sel", 64'(out_sel), 64'(i % 8));
      end

      // Channels 7 and 0 with backpressure after the first beat
      reset = 1'b1; step(); reset = 1'b0;
      in_valid = 8'h81; rand_data();
      step();
      chk("bp_first_sel", 64'(out_sel), 64'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         step();
         chk("bp_hold_sel", 64'(out_sel), 64'd0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         step();
         chk("bp_alt_sel", 64'(out_sel), (i % 2 == 0) ? 64'd7 : 64'd0);
      end

      // Out-of-range select on the 6-channel instance
      reset = 1'b1; step(); reset = 1'b0;
      mode = 1'b1; in_valid = 8'hFF;
      for (int s = 6; s < 8; s++) begin
         sel = 3'(s);
         for (int i = 0; i < 2; i++) begin
            rand_data();
            #1 chk("oor_rdy6", 64'(in_ready6), 64'h0);
            step();
            chk("oor_valid6", 64'(out_valid6), 64'(0));
         end
      end
      sel = 3'd5; rand_data();
      #1 chk("sel5_rdy6", 64'(in_ready6), 64'h20);
      step();
      chk("sel5_valid6", 64'(out_valid6), 64'(1));
      chk("sel5_sel6", 64'(out_sel6), 64'd5);
      chk("sel5_data6", 64'(out_data6), 64'(in_data[47:40]));

`ifdef STREAM_MUX_LOCK_EN
      // Three-beat packet on channel 1 holds off channel 2
      reset = 1'b1; step(); reset = 1'b0;
      mode = 1'b0; in_valid = 8'h06; in_last = 8'h00;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         if (i == 2) in_last = 8'h02;
         if (i == 3) in_last = 8'hFF;
         step();
         chk("lock_sel", 64'(out_sel), (i < 3) ? 64'd1 : 64'd2);
      end
      chk("lock_p", 64'(m_p), 64'd3);
      in_last = 8'hFF;
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
         sel       = 3'($urandom);
         in_valid  = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_last   = 8'($urandom);
         rand_data();
         step();
      end

      // Reset while a beat is stalled in the output register
      reset = 1'b0; mode = 1'b0; in_valid = 8'h10; out_ready = 1'b1; in_last = 8'hFF;
      rand_data(); step();
      out_ready = 1'b0; step();
      chk("mid_pre_valid", 64'(out_valid), 64'(1));
      reset = 1'b1; in_valid = 8'hFF;
      step();
      chk("mid_rst_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_sel", 64'(out_sel), 64'd0);
      reset = 1'b0; out_ready = 1'b1; rand_data();
      step();
      chk("mid_rr_start", 64'(out_sel), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised, registered N-to-1 multiplexer for valid/ready streams of width W. It supports two modes: software-forced select, the successor of the fixed-select muxes, and round-robin arbitration across all requesting channels. It sits between several producers and one consumer and adds one register stage on the output path. Optional packet locking keeps a grant for a whole multi-beat packet.

## Interface
Parameters:
- N, 8: number of input channels, 2..64
- W, 8: data width per channel, ≥1
- SEL_W, $clog2(N): select/channel-index width (derived, not overridden)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- mode  in  1  0 = round-robin, 1 = fixed select
- sel  in  SEL_W  channel index used when mode=1
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready, at most one bit high
- in_last  in  N  end-of-packet flag; present only with STREAM_MUX_LOCK_EN
- out_data  out  W  registered data
- out_valid  out  1  registered valid
- out_ready  in  1  consumer ready
- out_sel  out  SEL_W  index of the channel that supplied out_data
- out_last  out  1  registered last flag; present only with STREAM_MUX_LOCK_EN

## Operation
- Transfer occurs on any interface when valid & ready are both high at a rising edge.
- Output stage has load enable `ld = !out_valid | out_ready`.
- Grant vector g (one-hot or zero) is combinational from in_valid, mode, sel, the RR pointer and the lock state.
- in_ready = g & {N{ld}}.
- Fixed mode:
  - g[sel] = in_valid[sel].
  - sel ≥ N → g = 0; no channel is ever ready.
- Round-robin mode:
  - Scan starts at pointer p and takes the first valid channel at p, p+1, …, N-1, 0, …, p-1.
  - After a transfer from channel k, p ← (k+1) mod N. Wrap from N-1 goes to 0.
  - p is unchanged when no transfer occurs. p is also updated by transfers made in fixed mode.
- Output register on ld:
  - Transfer in progress: out_valid←1, out_data←in_data[k], out_sel←k.
  - No transfer: out_valid←0, and out_data and out_sel hold.
- Mode or sel changes take effect on the same cycle's grant. A beat already in the output register is unaffected.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, p=0, lock cleared.
- Reset asserted mid-stream discards any registered beat. in_ready is 0 while reset is high.

## Timing
- Latency is 1 cycle, input transfer to out_valid.
- Throughput is 1 beat/cycle while out_ready stays high.
- With out_ready low and out_valid high, ld=0, so all in_ready=0 and the output holds stable. No skid buffer.
- When out_ready returns high, a new beat can be accepted in that same cycle (simultaneous drain and fill).
- out_data, out_sel and out_last are stable whenever out_valid=1 and out_ready=0.

## Configuration
- Macro STREAM_MUX_LOCK_EN.
- Defined:
  - in_last and out_last ports exist.
  - A transfer with in_last[k]=0 sets lock to channel k.
  - While locked, g = in_valid[k] at channel k only, regardless of mode, sel or p.
  - A transfer with in_last[k]=1 clears the lock and advances p.
  - p advances only on a last beat.
  - out_last is registered alongside data.
- Undefined:
  - No in_last or out_last ports.
  - Every beat is arbitrated independently.

## Structure
- Package stream_mux_pkg holds:
  - MODE_RR=1'b0, MODE_FIXED=1'b1
  - localparam function for the SEL_W computation
- Sub-module rr_arbiter (parameter N) holds the round-robin logic.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: one-hot gnt[N] and the encoded gnt_idx.
  - Purely combinational. Pointer and lock registers stay in stream_mux.

## Test plan
- Reset, then N=8, W=8, mode=1, sel=3, in_valid=8'h08, in_data ch3=8'hA5, out_ready=1 → in_ready=8'h08. Next cycle out_valid=1, out_data=A5, out_sel=3.
- mode=1, sel=9 with N=16, channel 9 invalid → in_ready=0 and out_valid=0 every cycle. Then sel=15 → out_sel=15 from channel 15's data.
- mode=0, all 8 channels valid continuously, out_ready=1 → out_sel sequence 0,1,…,7,0 (wrap), one beat per cycle.
- mode=0, in_valid=8'h81, out_ready low for 3 cycles after the first beat → out_data held for 3 cycles with in_ready=0. Then channel 7 and channel 0 alternate.
- With STREAM_MUX_LOCK_EN, mode=0, channels 1 and 2 valid, channel 1 sends 3 beats with last on the 3rd → out_sel=1,1,1, then 2. p=2 after the packet.
- Reset asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_sel=0, and the next round-robin grant starts at channel 0.
